// File: rtl/io_input_conditioner.sv
// Board switch/pushbutton conditioner: 2-flop sync, debounce, sticky press flags, registered CPU read port.
// Optional press counter enabled by defining KEY_PRESS_COUNT_EN.

module io_ic_debounce #(
    parameter int W               = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] lvl_i,
    input  logic [W-1:0] prev_i,
    output logic [W-1:0] stable_d_o,
    output logic [W-1:0] stable_o
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Accept on the cycle the count would reach DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     stable_q, stable_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (lvl_i != prev_i || lvl_i == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = lvl_i;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_d_o = stable_d;
    assign stable_o   = stable_q;
endmodule

module io_input_conditioner #(
    parameter int SW_W            = 18,
    parameter int KEY_W           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  sw_in,
    input  logic [KEY_W-1:0] key_n_in,
    output logic [SW_W-1:0]  sw_stable,
    output logic [KEY_W-1:0] key_level,
    output logic [KEY_W-1:0] key_pending,
    input  logic             rd_en,
    input  logic [1:0]       rd_sel,
    output logic [31:0]      rd_data,
    output logic             rd_valid
);
    logic [SW_W-1:0]  sw_s1_q, sw_s2_q, sw_prev_q;
    logic [KEY_W-1:0] key_s1_q, key_s2_q, key_prev_q;
    logic [KEY_W-1:0] key_lvl_d, key_lvl_q, key_rise;
    logic [KEY_W-1:0] pend_q, pend_d, pend_clr;
    logic [SW_W-1:0]  sw_stable_d_unused;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q;

    // Key sync flops idle at 1 (released); key_prev_q holds the inverted, active-high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            sw_prev_q  <= '0;
            key_s1_q   <= '1;
            key_s2_q   <= '1;
            key_prev_q <= '0;
        end else begin
            sw_s1_q    <= sw_in;
            sw_s2_q    <= sw_s1_q;
            sw_prev_q  <= sw_s2_q;
            key_s1_q   <= key_n_in;
            key_s2_q   <= key_s1_q;
            key_prev_q <= ~key_s2_q;
        end
    end

    io_ic_debounce #(.W(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk        (clk),
        .rst        (rst),
        .lvl_i      (sw_s2_q),
        .prev_i     (sw_prev_q),
        .stable_d_o (sw_stable_d_unused),
        .stable_o   (sw_stable)
    );

    for (genvar i = 0; i < KEY_W; i++) begin : g_key_db
        io_ic_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
            .clk        (clk),
            .rst        (rst),
            .lvl_i      (~key_s2_q[i]),
            .prev_i     (key_prev_q[i]),
            .stable_d_o (key_lvl_d[i]),
            .stable_o   (key_lvl_q[i])
        );
    end

    assign key_rise = key_lvl_d & ~key_lvl_q;

`ifdef KEY_PRESS_COUNT_EN
    logic [15:0] cnt_q, cnt_inc;

    always_comb begin
        cnt_inc = '0;
        for (int i = 0; i < KEY_W; i++) cnt_inc = cnt_inc + {15'd0, key_rise[i]};
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_q + cnt_inc;
    end
`endif

    always_comb begin
        rd_data_d = rd_data_q;
        pend_clr  = '0;
        if (rd_en) begin
            case (rd_sel)
                2'd0: rd_data_d = 32'(sw_stable);
                2'd1: rd_data_d = 32'(key_lvl_q);
                2'd2: begin
                    rd_data_d = 32'(pend_q);
                    pend_clr  = pend_q;
                end
`ifdef KEY_PRESS_COUNT_EN
                default: rd_data_d = {16'd0, cnt_q};
`else
                default: rd_data_d = 32'd0;
`endif
            endcase
        end
    end

    // A press landing on the clear edge survives: set wins over read-clear.
    assign pend_d = (pend_q & ~pend_clr) | key_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
        end
    end

    assign key_level   = key_lvl_q;
    assign key_pending = pend_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES=4 (latency 6 cycles).
module tb_io_input_conditioner;
    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] sw_in;
    logic [3:0]  key_n_in;
    logic [17:0] sw_stable;
    logic [3:0]  key_level;
    logic [3:0]  key_pending;
    logic        rd_en;
    logic [1:0]  rd_sel;
    logic [31:0] rd_data;
    logic        rd_valid;

    int checks = 0;
    int errors = 0;

    io_input_conditioner #(.SW_W(18), .KEY_W(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .key_n_in(key_n_in),
        .sw_stable(sw_stable), .key_level(key_level), .key_pending(key_pending),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; rd_en = 1'b0; rd_sel = 2'd0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; sw_in = 18'd12345; key_n_in = 4'hF; rd_en = 1'b0; rd_sel = 2'd0;
        tick(3);
        checks++;
        if ({sw_stable, key_level, key_pending, rd_data, rd_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got sw=%0d lvl=%b pend=%b data=%0d vld=%b exp all 0",
                     sw_stable, key_level, key_pending, rd_data, rd_valid);
        end
    endtask

    task automatic test_sw_latency;
        rst = 1'b0;
        tick(5);
        checks++;
        if (sw_stable !== 18'd0) begin
            errors++; $display("FAIL sw_early got %0d exp 0", sw_stable);
        end
        tick(1);
        checks++;
        if (sw_stable !== 18'd12345) begin
            errors++; $display("FAIL sw_latency got %0d exp 12345", sw_stable);
        end
    endtask

    task automatic test_read_back_to_back;
        rd_en = 1'b1; rd_sel = 2'd0;
        tick(1);
        rd_sel = 2'd1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd12345) begin
            errors++; $display("FAIL rd_sw got vld=%b data=%0d exp 1/12345", rd_valid, rd_data);
        end
        tick(1);
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
            errors++; $display("FAIL rd_lvl b2b got vld=%b data=%0d exp 1/0", rd_valid, rd_data);
        end
        tick(1);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL rd_valid_drop got %b exp 0", rd_valid);
        end
    endtask

    task automatic test_glitch;
        key_n_in = 4'b1101;
        tick(3);
        key_n_in = 4'hF;
        tick(10);
        checks++;
        if (key_level !== 4'b0 || key_pending !== 4'b0) begin
            errors++; $display("FAIL glitch got lvl=%b pend=%b exp 0000/0000", key_level, key_pending);
        end
    endtask

    task automatic test_press;
        key_n_in = 4'b1101;
        tick(5);
        checks++;
        if (key_level !== 4'b0000) begin
            errors++; $display("FAIL press_early got %b exp 0000", key_level);
        end
        tick(1);
        checks++;
        if (key_level !== 4'b0010 || key_pending !== 4'b0010) begin
            errors++; $display("FAIL press got lvl=%b pend=%b exp 0010/0010", key_level, key_pending);
        end
        tick(4);
        key_n_in = 4'hF;
        tick(8);
        checks++;
        if (key_level !== 4'b0000 || key_pending !== 4'b0010) begin
            errors++; $display("FAIL release got lvl=%b pend=%b exp 0000/0010", key_level, key_pending);
        end
        rd_en = 1'b1; rd_sel = 2'd2;
        tick(1);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd2 || key_pending !== 4'b0000) begin
            errors++; $display("FAIL rd_pend got vld=%b data=%0d pend=%b exp 1/2/0000", rd_valid, rd_data, key_pending);
        end
        tick(1);
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
            errors++; $display("FAIL rd_pend2 got vld=%b data=%0d exp 1/0", rd_valid, rd_data);
        end
        tick(1);
    endtask

    task automatic test_set_wins;
        key_n_in = 4'b1110;
        tick(8);
        key_n_in = 4'hF;
        tick(8);
        checks++;
        if (key_pending !== 4'b0001) begin
            errors++; $display("FAIL setup_pend got %b exp 0001", key_pending);
        end
        key_n_in = 4'b1011;
        tick(5);
        rd_en = 1'b1; rd_sel = 2'd2;
        tick(1);
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'd1 || key_pending !== 4'b0100 || key_level !== 4'b0100) begin
            errors++; $display("FAIL set_wins got data=%0d pend=%b lvl=%b exp 1/0100/0100", rd_data, key_pending, key_level);
        end
        key_n_in = 4'hF;
        tick(8);
    endtask

    task automatic test_count;
        logic [31:0] exp;
`ifdef KEY_PRESS_COUNT_EN
        exp = 32'd6;
`else
        exp = 32'd0;
`endif
        do_reset();
        tick(2);
        for (int n = 0; n < 3; n++) begin
            key_n_in = 4'b0110;
            tick(8);
            key_n_in = 4'hF;
            tick(8);
        end
        rd_en = 1'b1; rd_sel = 2'd3;
        tick(1);
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp || key_pending !== 4'b1001) begin
            errors++; $display("FAIL count got vld=%b data=%0d pend=%b exp 1/%0d/1001", rd_valid, rd_data, key_pending, exp);
        end
        tick(1);
    endtask

    task automatic test_reset_mid;
        tick(6);
        rd_en = 1'b1; rd_sel = 2'd0;
        tick(1);
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'd12345 || key_pending !== 4'b1001) begin
            errors++; $display("FAIL pre_reset got data=%0d pend=%b exp 12345/1001", rd_data, key_pending);
        end
        key_n_in = 4'b1101;
        tick(4);
        rst = 1'b1; rd_en = 1'b1; rd_sel = 2'd1;
        tick(1);
        checks++;
        if ({sw_stable, key_level, key_pending, rd_data, rd_valid} !== '0) begin
            errors++;
            $display("FAIL reset_mid got sw=%0d lvl=%b pend=%b data=%0d vld=%b exp all 0",
                     sw_stable, key_level, key_pending, rd_data, rd_valid);
        end
        rst = 1'b0; rd_en = 1'b0; key_n_in = 4'hF;
        tick(1);
        checks++;
        if (rd_valid !== 1'b0 || key_pending !== 4'b0) begin
            errors++; $display("FAIL post_reset got vld=%b pend=%b exp 0/0000", rd_valid, key_pending);
        end
    endtask

    initial begin
        test_reset();
        test_sw_latency();
        test_read_back_to_back();
        test_glitch();
        test_press();
        test_set_wins();
        test_count();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
